// File: rtl/div_unit_if.sv
// Handshake bundle for div_unit: operand/op request side and result side.
// master = issuing pipeline stage, slave = divide unit.
interface div_unit_if #(
  parameter int unsigned DWIDTH = 32
) ();

  // Request side
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] ina;
  logic [DWIDTH-1:0] inb;
  logic [1:0]        op;
  logic              flush;

  // Result side
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out;

  modport master (
    output in_valid,
    output ina,
    output inb,
    output op,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out
  );

  modport slave (
    input  in_valid,
    input  ina,
    input  inb,
    input  op,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out
  );

endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring division on operand magnitudes, one quotient bit per cycle,
// sign fix-up applied on the final iteration edge.
// op encoding (funct3[1:0]): 00 DIV, 01 DIVU, 10 REM, 11 REMU.
// Optional feature: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_unit #(
  parameter int unsigned DWIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  div_unit_if.slave bus
);

  localparam int unsigned CntW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [DWIDTH-1:0] MinNeg = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [CntW-1:0] CntLast = CntW'(DWIDTH - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DWIDTH:0]   rem_q, rem_d;   // one guard bit above the remainder
  logic [DWIDTH-1:0] quo_q, quo_d;   // holds dividend magnitude, shifts into quotient
  logic [DWIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [1:0]        op_q, op_d;
  logic              a_neg_q, a_neg_d;
  logic              b_neg_q, b_neg_d;
  logic [DWIDTH-1:0] out_q, out_d;

  // Request decode
  logic              accept;
  logic              signed_op;
  logic              a_neg, b_neg;
  logic [DWIDTH-1:0] mag_a, mag_b;
  logic              div_zero;
  logic              sgn_ovf;
  logic              early_out;
  logic              special;
  logic [DWIDTH-1:0] special_res;

  // Iteration datapath
  logic [DWIDTH:0]   shifted;
  logic [DWIDTH:0]   diff;
  logic              iter_ge;
  logic [DWIDTH:0]   rem_iter;
  logic [DWIDTH-1:0] quo_iter;
  logic [DWIDTH-1:0] quo_fix;
  logic [DWIDTH-1:0] rem_fix;
  logic [DWIDTH-1:0] res_fix;

  // Handshake outputs depend on state only
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out       = out_q;

  assign accept = bus.in_valid & bus.in_ready;

  // Operand magnitudes and the cases that bypass the iteration loop
  always_comb begin
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.ina[DWIDTH-1];
    b_neg     = signed_op & bus.inb[DWIDTH-1];
    mag_a     = a_neg ? -bus.ina : bus.ina;
    mag_b     = b_neg ? -bus.inb : bus.inb;
    div_zero  = (bus.inb == '0);
    sgn_ovf   = signed_op && (bus.ina == MinNeg) && (bus.inb == '1);
`ifdef DIV_EARLY_OUT_EN
    early_out = !div_zero && (mag_a < mag_b);
`else
    early_out = 1'b0;
`endif
    special   = div_zero | sgn_ovf | early_out;

    // Quotient or remainder selected by op[1]
    if (div_zero) begin
      special_res = bus.op[1] ? bus.ina : '1;
    end else if (sgn_ovf) begin
      special_res = bus.op[1] ? '0 : MinNeg;
    end else begin
      special_res = bus.op[1] ? bus.ina : '0;
    end
  end

  // One restoring step plus the sign fix-up used on the last step
  always_comb begin
    shifted  = {rem_q[DWIDTH-1:0], quo_q[DWIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    iter_ge  = ~diff[DWIDTH];
    rem_iter = iter_ge ? diff : shifted;
    quo_iter = {quo_q[DWIDTH-2:0], iter_ge};

    quo_fix  = ((op_q == 2'b00) && (a_neg_q ^ b_neg_q)) ? -quo_iter : quo_iter;
    rem_fix  = ((op_q == 2'b10) && a_neg_q) ? -rem_iter[DWIDTH-1:0] : rem_iter[DWIDTH-1:0];
    res_fix  = op_q[1] ? rem_fix : quo_fix;
  end

  // FSM next-state; flush overrides every other transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = special ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.flush) begin
      state_d = StIdle;
    end
  end

  // Datapath next-state: latch on accept, iterate in CALC, register result on completion
  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    op_d    = op_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    out_d   = out_q;

    if (!bus.flush) begin
      if ((state_q == StIdle) && accept) begin
        op_d    = bus.op;
        a_neg_d = a_neg;
        b_neg_d = b_neg;
        quo_d   = mag_a;
        dvs_d   = mag_b;
        rem_d   = '0;
        cnt_d   = CntLast;
        if (special) begin
          out_d = special_res;
        end
      end else if (state_q == StCalc) begin
        rem_d = rem_iter;
        quo_d = quo_iter;
        if (cnt_q == '0) begin
          out_d = res_fix;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      op_q    <= op_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed + random bench for div_unit with an expected-result scoreboard.
module tb_div_unit;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] MinNeg = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  div_unit_if #(.DWIDTH(W)) bus ();

  div_unit #(.DWIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference RV32M semantics
  function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    if (b == '0) begin
      r = op[1] ? a : '1;
    end else if (!op[0] && a == MinNeg && b == '1) begin
      r = op[1] ? '0 : MinNeg;
    end else if (!op[0]) begin
      r = op[1] ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
    end else begin
      r = op[1] ? (a % b) : (a / b);
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    logic [W-1:0] ma, mb;
    ma = (!op[0] && a[W-1]) ? -a : a;
    mb = (!op[0] && b[W-1]) ? -b : b;
    if (b == '0) return 1;
    if (!op[0] && a == MinNeg && b == '1) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return W + 1;
  endfunction

  // Issue one operation, wait for its result, optionally stall the consumer, then retire it
  task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold);
    logic [W-1:0] e;
    int el;
    int lat;
    exp_q.push_back(ref_res(op, a, b));
    lat_q.push_back(ref_lat(op, a, b));
    @(negedge clk);
    chk({tag, "/in_ready"}, W'(bus.in_ready), W'(1));
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.ina      = a;
    bus.inb      = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    chk({tag, "/lat"}, W'(lat), W'(el));
    chk({tag, "/out"}, bus.out, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "/hold_out"}, bus.out, e);
      chk({tag, "/hold_vld_rdy"}, W'({bus.out_valid, bus.in_ready}), W'(2'b10));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "/idle"}, W'({bus.in_ready, bus.out_valid}), W'(2'b10));
  endtask

  initial begin
    logic [W-1:0] prev_out;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    int           seen;

    bus.in_valid  = 1'b0;
    bus.ina       = '0;
    bus.inb       = '0;
    bus.op        = 2'b00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset/rdy_vld", W'({bus.in_ready, bus.out_valid}), W'(2'b10));
    chk("reset/out", bus.out, '0);
    rst_n = 1'b1;

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
    do_op("div_m7_2", 2'b00, -32'sd7, 32'd2, 0);
    do_op("rem_m7_2", 2'b10, -32'sd7, 32'd2, 0);
    do_op("rem_7_m2", 2'b10, 32'd7, -32'sd2, 0);
    do_op("div_5_0", 2'b00, 32'd5, 32'd0, 0);
    do_op("rem_5_0", 2'b10, 32'd5, 32'd0, 0);
    do_op("divu_5_0", 2'b01, 32'd5, 32'd0, 0);
    do_op("div_ovf", 2'b00, MinNeg, 32'hFFFF_FFFF, 0);
    do_op("rem_ovf", 2'b10, MinNeg, 32'hFFFF_FFFF, 0);
    do_op("divu_min_m1", 2'b01, MinNeg, 32'hFFFF_FFFF, 0);
    do_op("remu_min_m1", 2'b11, MinNeg, 32'hFFFF_FFFF, 0);
    do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("divu_3_9", 2'b01, 32'd3, 32'd9, 0);
    do_op("rem_m3_9", 2'b10, -32'sd3, 32'd9, 0);
    do_op("div_min_2", 2'b00, MinNeg, 32'd2, 0);
    do_op("stall10", 2'b00, 32'd1000, -32'sd33, 10);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      do_op("rand", rop, ra, rb, 0);
    end

    // Flush in the fifth CALC cycle: result discarded, out unchanged
    prev_out = bus.out;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 2'b01;
    bus.ina      = 32'd1000;
    bus.inb      = 32'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush/idle", W'({bus.in_ready, bus.out_valid}), W'(2'b10));
    chk("flush/out", bus.out, prev_out);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("flush/no_valid", W'(seen), W'(0));

    do_op("after_flush", 2'b00, 32'd77, 32'd7, 0);

    // Async reset pulse mid-CALC
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 2'b01;
    bus.ina      = 32'd123456;
    bus.inb      = 32'd10;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid/rdy_vld", W'({bus.in_ready, bus.out_valid}), W'(2'b10));
    chk("rst_mid/out", bus.out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("after_rst", 2'b10, -32'sd100, 32'd7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
